// File: rtl/fmap_mem_responder.sv
// -----------------------------------------------------------------------------
// fmap_mem_responder
//
// This is the feature-map scratchpad for the pooling and convolution engines.
// Those engines issue the requests, and this block responds to them.
//
// Read channel
//   - The request side uses a valid/ready handshake.
//   - Responses go through a 2-entry FIFO, so an engine that stalls its
//     response side never loses data.
//   - The array is read at the accept edge. The response is visible on the
//     next cycle.
//
// Write channel
//   - Writes take a single cycle, are byte-enabled and never stall.
//
// Out-of-range addresses (>= DEPTH)
//   - A read returns data=0 with err=1. It still occupies a FIFO slot.
//   - A write is dropped.
//
// Storage contents are not cleared by reset.
//
// Optional build macro: FMAP_MEM_STATS_EN
//   When it is defined, two extra outputs are added:
//   - rd_count: number of accepted reads.
//   - wr_count: number of accepted in-range writes.
//   Both counters saturate and are cleared by reset.
//
// Ports
//   clk, rst_n                          clock, async active-low reset
//   rd_req_valid/ready, rd_req_addr     read request
//   rd_rsp_valid/ready, rd_rsp_data/err read response (head of response FIFO)
//   wr_valid/ready, wr_addr/data/be     byte-enabled write
//   busy                                one or more responses buffered
//   rd_count, wr_count                  (FMAP_MEM_STATS_EN only) statistics
// -----------------------------------------------------------------------------
module fmap_mem_responder #(
    parameter int ADDR_WIDTH = 12,
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 4096
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    rd_req_valid,
    output logic                    rd_req_ready,
    input  logic [ADDR_WIDTH-1:0]   rd_req_addr,
    output logic                    rd_rsp_valid,
    input  logic                    rd_rsp_ready,
    output logic [DATA_WIDTH-1:0]   rd_rsp_data,
    output logic                    rd_rsp_err,
    input  logic                    wr_valid,
    output logic                    wr_ready,
    input  logic [ADDR_WIDTH-1:0]   wr_addr,
    input  logic [DATA_WIDTH-1:0]   wr_data,
    input  logic [DATA_WIDTH/8-1:0] wr_be,
    output logic                    busy
`ifdef FMAP_MEM_STATS_EN
    ,
    output logic [15:0]             rd_count,
    output logic [15:0]             wr_count
`endif
);

    localparam int BE_W  = DATA_WIDTH / 8;
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_WIDTH:0] DEPTH_EXT = (ADDR_WIDTH + 1)'(DEPTH);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic [DATA_WIDTH-1:0] fifo_data [2];
    logic                  fifo_err  [2];
    logic                  wr_ptr;
    logic                  rd_ptr;
    logic [1:0]            count;

    logic                  rd_in_range;
    logic                  wr_in_range;
    logic                  not_full;
    logic                  push;
    logic                  pop;
    logic                  wr_en;
    logic [IDX_W-1:0]      rd_idx;
    logic [IDX_W-1:0]      wr_idx;

    // Range checks use one extra bit, so DEPTH == 2^ADDR_WIDTH still compares
    // correctly. Addresses are never aliased into the array.
    assign rd_in_range = ({1'b0, rd_req_addr} < DEPTH_EXT);
    assign wr_in_range = ({1'b0, wr_addr} < DEPTH_EXT);
    assign rd_idx      = rd_req_addr[IDX_W-1:0];
    assign wr_idx      = wr_addr[IDX_W-1:0];

    // The internal handshake terms are derived from count only.
    // rst_n gates only the visible ready outputs.
    assign not_full     = (count != 2'd2);
    assign push         = rd_req_valid & not_full;
    assign pop          = rd_rsp_valid & rd_rsp_ready;
    assign wr_en        = wr_valid & wr_in_range;

    assign rd_req_ready = rst_n & not_full;
    assign wr_ready     = rst_n;
    assign rd_rsp_valid = (count != 2'd0);
    assign busy         = (count != 2'd0);
    assign rd_rsp_data  = fifo_data[rd_ptr];
    assign rd_rsp_err   = fifo_err[rd_ptr];

    // Storage has no reset.
    // The read of mem below samples the pre-write value at the same edge,
    // which gives read-first behaviour for same-address collisions.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int i = 0; i < BE_W; i++) begin
                if (wr_be[i]) begin
                    mem[wr_idx][i*8 +: 8] <= wr_data[i*8 +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 2; i++) begin
                fifo_data[i] <= '0;
                fifo_err[i]  <= 1'b0;
            end
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (push) begin
                fifo_data[wr_ptr] <= rd_in_range ? mem[rd_idx] : '0;
                fifo_err[wr_ptr]  <= ~rd_in_range;
                wr_ptr            <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

`ifdef FMAP_MEM_STATS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_count <= 16'd0;
            wr_count <= 16'd0;
        end else begin
            if (push && rd_count != 16'hFFFF) begin
                rd_count <= rd_count + 16'd1;
            end
            if (wr_en && wr_count != 16'hFFFF) begin
                wr_count <= wr_count + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_fmap_mem_responder.sv
// -----------------------------------------------------------------------------
// tb_fmap_mem_responder
//
// Directed, self-checking bench for fmap_mem_responder.
// The DUT is built with DEPTH=3000 so that addresses 0xBB8 and above are out
// of range.
// The statistics checks are compiled only when FMAP_MEM_STATS_EN is defined.
// -----------------------------------------------------------------------------
module tb_fmap_mem_responder;

    logic        clk;
    logic        rst_n;
    logic        rd_req_valid;
    logic        rd_req_ready;
    logic [11:0] rd_req_addr;
    logic        rd_rsp_valid;
    logic        rd_rsp_ready;
    logic [31:0] rd_rsp_data;
    logic        rd_rsp_err;
    logic        wr_valid;
    logic        wr_ready;
    logic [11:0] wr_addr;
    logic [31:0] wr_data;
    logic [3:0]  wr_be;
    logic        busy;
`ifdef FMAP_MEM_STATS_EN
    logic [15:0] rd_count;
    logic [15:0] wr_count;
`endif

    int errors = 0;
    int checks = 0;

    fmap_mem_responder #(
        .ADDR_WIDTH(12),
        .DATA_WIDTH(32),
        .DEPTH     (3000)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .rd_req_valid(rd_req_valid),
        .rd_req_ready(rd_req_ready),
        .rd_req_addr (rd_req_addr),
        .rd_rsp_valid(rd_rsp_valid),
        .rd_rsp_ready(rd_rsp_ready),
        .rd_rsp_data (rd_rsp_data),
        .rd_rsp_err  (rd_rsp_err),
        .wr_valid    (wr_valid),
        .wr_ready    (wr_ready),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .wr_be       (wr_be),
        .busy        (busy)
`ifdef FMAP_MEM_STATS_EN
        ,
        .rd_count    (rd_count),
        .wr_count    (wr_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Stimulus helpers: they drive the DUT and return observations.
    // They make no comparisons themselves.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_write(input logic [11:0] a, input logic [31:0] d, input logic [3:0] be);
        wr_valid = 1'b1;
        wr_addr  = a;
        wr_data  = d;
        wr_be    = be;
        step();
        wr_valid = 1'b0;
        wr_be    = 4'h0;
    endtask

    // Issues one read with rd_rsp_ready high.
    // Samples the response one cycle after the accept, then lets it pop.
    task automatic do_read(input logic [11:0] a, output logic v, output logic [31:0] d, output logic e);
        rd_rsp_ready = 1'b1;
        rd_req_valid = 1'b1;
        rd_req_addr  = a;
        step();
        rd_req_valid = 1'b0;
        v = rd_rsp_valid;
        d = rd_rsp_data;
        e = rd_rsp_err;
        step();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        step();
        step();
        checks++; if (rd_rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid: got %b expected 0", rd_rsp_valid); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
        checks++; if (rd_rsp_data !== 32'h0) begin errors++; $display("FAIL reset_rsp_data: got %h expected 0", rd_rsp_data); end
        checks++; if (rd_rsp_err !== 1'b0) begin errors++; $display("FAIL reset_rsp_err: got %b expected 0", rd_rsp_err); end
        checks++; if (rd_req_ready !== 1'b0) begin errors++; $display("FAIL reset_req_ready: got %b expected 0", rd_req_ready); end
        checks++; if (wr_ready !== 1'b0) begin errors++; $display("FAIL reset_wr_ready: got %b expected 0", wr_ready); end
        rst_n = 1'b1;
        #1;
        checks++; if (rd_req_ready !== 1'b1) begin errors++; $display("FAIL post_reset_req_ready: got %b expected 1", rd_req_ready); end
        checks++; if (wr_ready !== 1'b1) begin errors++; $display("FAIL post_reset_wr_ready: got %b expected 1", wr_ready); end
        step();
    endtask

    task automatic test_write_read();
        logic v, e;
        logic [31:0] d;
        do_write(12'h010, 32'hDEADBEEF, 4'hF);
        do_read(12'h010, v, d, e);
        checks++; if (v !== 1'b1) begin errors++; $display("FAIL wr_rd_valid: got %b expected 1", v); end
        checks++; if (d !== 32'hDEADBEEF) begin errors++; $display("FAIL wr_rd_data: got %h expected deadbeef", d); end
        checks++; if (e !== 1'b0) begin errors++; $display("FAIL wr_rd_err: got %b expected 0", e); end
    endtask

    task automatic test_byte_enable();
        logic v, e;
        logic [31:0] d;
        do_write(12'h010, 32'h11223344, 4'b0101);
        do_read(12'h010, v, d, e);
        checks++; if (d !== 32'hDE22BE44) begin errors++; $display("FAIL be_partial: got %h expected de22be44", d); end
        do_write(12'h010, 32'hFFFFFFFF, 4'b0000);
        do_read(12'h010, v, d, e);
        checks++; if (d !== 32'hDE22BE44) begin errors++; $display("FAIL be_zero: got %h expected de22be44", d); end
        do_write(12'h010, 32'hA5000000, 4'b1000);
        do_read(12'h010, v, d, e);
        checks++; if (d !== 32'hA522BE44) begin errors++; $display("FAIL be_top: got %h expected a522be44", d); end
    endtask

    task automatic test_backpressure();
        do_write(12'h001, 32'd1, 4'hF);
        do_write(12'h002, 32'd2, 4'hF);
        do_write(12'h003, 32'd3, 4'hF);
        rd_rsp_ready = 1'b0;
        rd_req_valid = 1'b1;
        rd_req_addr  = 12'h001;
        step();
        checks++; if (rd_req_ready !== 1'b1) begin errors++; $display("FAIL bp_ready_one: got %b expected 1", rd_req_ready); end
        rd_req_addr = 12'h002;
        step();
        checks++; if (rd_req_ready !== 1'b0) begin errors++; $display("FAIL bp_ready_full: got %b expected 0", rd_req_ready); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL bp_busy: got %b expected 1", busy); end
        rd_req_addr = 12'h003;
        step();
        checks++; if (rd_rsp_data !== 32'd1) begin errors++; $display("FAIL bp_stall_data0: got %h expected 1", rd_rsp_data); end
        step();
        checks++; if (rd_rsp_data !== 32'd1 || rd_rsp_valid !== 1'b1) begin errors++; $display("FAIL bp_stall_data1: got %h/%b expected 1/1", rd_rsp_data, rd_rsp_valid); end
        checks++; if (rd_req_ready !== 1'b0) begin errors++; $display("FAIL bp_still_full: got %b expected 0", rd_req_ready); end
        // The head (1) pops at the next edge. The third request is blocked
        // at that edge and gets in one edge later.
        rd_rsp_ready = 1'b1;
        step();
        checks++; if (rd_rsp_data !== 32'd2) begin errors++; $display("FAIL bp_order2: got %h expected 2", rd_rsp_data); end
        step();
        rd_req_valid = 1'b0;
        checks++; if (rd_rsp_data !== 32'd3 || rd_rsp_valid !== 1'b1) begin errors++; $display("FAIL bp_order3: got %h/%b expected 3/1", rd_rsp_data, rd_rsp_valid); end
        step();
        checks++; if (rd_rsp_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL bp_drained: got %b/%b expected 0/0", rd_rsp_valid, busy); end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 8; i++) begin
            do_write(12'h100 + 12'(i), 32'hA0 + 32'(i), 4'hF);
        end
        rd_rsp_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            rd_req_valid = 1'b1;
            rd_req_addr  = 12'h100 + 12'(i);
            step();
            checks++;
            if (rd_rsp_valid !== 1'b1 || rd_rsp_data !== 32'hA0 + 32'(i) || rd_req_ready !== 1'b1) begin
                errors++;
                $display("FAIL b2b_%0d: got v=%b d=%h rdy=%b expected v=1 d=%h rdy=1", i, rd_rsp_valid, rd_rsp_data, rd_req_ready, 32'hA0 + 32'(i));
            end
        end
        rd_req_valid = 1'b0;
        step();
        checks++; if (rd_rsp_valid !== 1'b0) begin errors++; $display("FAIL b2b_drained: got %b expected 0", rd_rsp_valid); end
    endtask

    task automatic test_out_of_range();
        logic v, e;
        logic [31:0] d;
        do_write(12'h000, 32'h12345678, 4'hF);
        do_read(12'hBB8, v, d, e);
        checks++; if (v !== 1'b1 || d !== 32'h0 || e !== 1'b1) begin errors++; $display("FAIL oor_read_bb8: got v=%b d=%h e=%b expected 1/0/1", v, d, e); end
        do_read(12'hFFF, v, d, e);
        checks++; if (d !== 32'h0 || e !== 1'b1) begin errors++; $display("FAIL oor_read_fff: got d=%h e=%b expected 0/1", d, e); end
        do_write(12'hBB8, 32'hFFFFFFFF, 4'hF);
        do_read(12'h000, v, d, e);
        checks++; if (d !== 32'h12345678 || e !== 1'b0) begin errors++; $display("FAIL oor_write_alias: got d=%h e=%b expected 12345678/0", d, e); end
        do_write(12'hBB7, 32'hCAFEF00D, 4'hF);
        do_read(12'hBB7, v, d, e);
        checks++; if (d !== 32'hCAFEF00D || e !== 1'b0) begin errors++; $display("FAIL last_word: got d=%h e=%b expected cafef00d/0", d, e); end
    endtask

    task automatic test_read_first();
        logic v, e;
        logic [31:0] d;
        do_write(12'h020, 32'd5, 4'hF);
        rd_rsp_ready = 1'b1;
        rd_req_valid = 1'b1;
        rd_req_addr  = 12'h020;
        wr_valid     = 1'b1;
        wr_addr      = 12'h020;
        wr_data      = 32'd9;
        wr_be        = 4'hF;
        step();
        rd_req_valid = 1'b0;
        wr_valid     = 1'b0;
        wr_be        = 4'h0;
        checks++; if (rd_rsp_data !== 32'd5) begin errors++; $display("FAIL read_first_old: got %h expected 5", rd_rsp_data); end
        step();
        do_read(12'h020, v, d, e);
        checks++; if (d !== 32'd9) begin errors++; $display("FAIL read_first_new: got %h expected 9", d); end
    endtask

    task automatic test_reset_mid();
        logic v, e;
        logic [31:0] d;
        rd_rsp_ready = 1'b0;
        rd_req_valid = 1'b1;
        rd_req_addr  = 12'h001;
        step();
        rd_req_addr  = 12'h002;
        step();
        rd_req_valid = 1'b0;
        checks++; if (busy !== 1'b1 || rd_req_ready !== 1'b0) begin errors++; $display("FAIL mid_prefill: got busy=%b rdy=%b expected 1/0", busy, rd_req_ready); end
        rst_n = 1'b0;
        #1;
        checks++; if (rd_rsp_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL mid_async_clear: got v=%b busy=%b expected 0/0", rd_rsp_valid, busy); end
        step();
        rst_n = 1'b1;
        rd_rsp_ready = 1'b1;
        step();
        step();
        checks++; if (rd_rsp_valid !== 1'b0) begin errors++; $display("FAIL mid_no_stale: got %b expected 0", rd_rsp_valid); end
        do_read(12'h010, v, d, e);
        checks++; if (d !== 32'hA522BE44) begin errors++; $display("FAIL mid_mem_kept10: got %h expected a522be44", d); end
        do_read(12'h001, v, d, e);
        checks++; if (d !== 32'd1) begin errors++; $display("FAIL mid_mem_kept1: got %h expected 1", d); end
    endtask

`ifdef FMAP_MEM_STATS_EN
    task automatic test_stats();
        logic v, e;
        logic [31:0] d;
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        step();
        checks++; if (rd_count !== 16'd0 || wr_count !== 16'd0) begin errors++; $display("FAIL stats_reset: got %0d/%0d expected 0/0", rd_count, wr_count); end
        do_read(12'h001, v, d, e);
        do_read(12'h002, v, d, e);
        do_read(12'h003, v, d, e);
        do_read(12'h010, v, d, e);
        do_read(12'hBB8, v, d, e);
        do_write(12'h200, 32'h1, 4'hF);
        do_write(12'h201, 32'h2, 4'h1);
        do_write(12'hBB8, 32'h3, 4'hF);
        do_write(12'h202, 32'h4, 4'h0);
        checks++; if (rd_count !== 16'd5) begin errors++; $display("FAIL stats_rd: got %0d expected 5", rd_count); end
        checks++; if (wr_count !== 16'd3) begin errors++; $display("FAIL stats_wr: got %0d expected 3", wr_count); end
    endtask
`endif

    initial begin
        rst_n        = 1'b0;
        rd_req_valid = 1'b0;
        rd_req_addr  = 12'h0;
        rd_rsp_ready = 1'b0;
        wr_valid     = 1'b0;
        wr_addr      = 12'h0;
        wr_data      = 32'h0;
        wr_be        = 4'h0;
        test_reset();
        test_write_read();
        test_byte_enable();
        test_backpressure();
        test_back_to_back();
        test_out_of_range();
        test_read_first();
        test_reset_mid();
`ifdef FMAP_MEM_STATS_EN
        test_stats();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/fmap_mem_responder.md
Name: fmap_mem_responder

Overview:
- Feature-map scratchpad that serves the memory side of the pooling/convolution engines.
- Engines act as initiators: they issue read requests and write results. This block responds.
- Read channel: valid/ready request plus a buffered valid/ready response, so an engine that stalls its response side never loses data.
- Write channel: single-cycle, byte-enabled.

Parameters:
- ADDR_WIDTH, 12: width of read and write addresses.
- DATA_WIDTH, 32: word width; must be a multiple of 8.
- DEPTH, 4096: number of implemented words; must be ≤ 2^ADDR_WIDTH.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous, active-low reset.
- rd_req_valid  in  1  read request valid.
- rd_req_ready  out  1  read request accepted when high together with valid.
- rd_req_addr  in  ADDR_WIDTH  word address to read.
- rd_rsp_valid  out  1  response valid.
- rd_rsp_ready  in  1  initiator can take the response.
- rd_rsp_data  out  DATA_WIDTH  read data.
- rd_rsp_err  out  1  request address was ≥ DEPTH.
- wr_valid  in  1  write strobe.
- wr_ready  out  1  write accepted.
- wr_addr  in  ADDR_WIDTH  word address to write.
- wr_data  in  DATA_WIDTH  write data.
- wr_be  in  DATA_WIDTH/8  byte enables; bit i covers byte i.
- busy  out  1  one or more responses are buffered.

Behaviour:
- Reset (rst_n low, asynchronous):
  - rd_rsp_valid=0, rd_rsp_data=0, rd_rsp_err=0, busy=0.
  - Response FIFO emptied, pointers=0.
  - rd_req_ready=0 and wr_ready=0 while rst_n is low.
  - Storage array is NOT cleared; contents survive reset.
- Reset asserted mid-operation: every buffered and in-flight response is discarded. No response is produced for requests accepted before reset.
- Response FIFO:
  - 2 entries, each holding {err, data}; count 0..2.
  - busy = (count != 0).
  - rd_rsp_valid = (count != 0). Head entry drives rd_rsp_data/rd_rsp_err.
- rd_req_ready = (count < 2), registered from count only. There is no combinational path from rd_rsp_ready.
- Read accept (rd_req_valid & rd_req_ready at edge N):
  - Array word read at edge N and pushed into the FIFO.
  - Response visible from cycle N+1, i.e. 1-cycle latency when the FIFO was empty.
- Pop: rd_rsp_valid & rd_rsp_ready at an edge.
- Push and pop at the same edge: count unchanged. This gives one read per cycle sustained.
- Responses return strictly in request order.
- rd_rsp_data and rd_rsp_err hold stable while rd_rsp_valid=1 and rd_rsp_ready=0.
- Out-of-range read (addr ≥ DEPTH): response data=0, err=1. It still occupies a FIFO slot.
- Write:
  - wr_ready=1 whenever rst_n is high; the write never stalls.
  - On wr_valid at an edge, byte i of mem[wr_addr] is updated only where wr_be[i]=1.
  - Out-of-range write is silently dropped.
- Same-edge read and write to the same address: the read returns pre-write data (read-first). The next read sees the new data.
- wr_be=0 with wr_valid=1: no change to memory.
- Address arithmetic is word-indexed; there is no wrap. Any address ≥ DEPTH is out of range, never aliased.

Optional Feature:
- Macro: FMAP_MEM_STATS_EN.
- When defined, two extra outputs are added:
  - rd_count, out, 16: accepted reads.
  - wr_count, out, 16: accepted in-range writes.
- Both counters saturate at 16'hFFFF and reset to 0 with rst_n.
- Out-of-range reads are counted in rd_count. Out-of-range writes are not counted in wr_count.
- When not defined, these ports and their logic are absent and the block behaves identically otherwise.

Test Plan:
- Write mem[0x010]=32'hDEADBEEF with wr_be=4'hF, then read 0x010 with rd_rsp_ready=1 -> rd_rsp_valid in the next cycle, data=32'hDEADBEEF, err=0.
- wr_be=4'b0101, wr_data=32'h11223344 over 32'hDEADBEEF at 0x010, then read -> 32'hDE22BE44.
- Hold rd_rsp_ready=0 and issue reads to 0x001, 0x002, 0x003 (mem=1,2,3):
  - After 2 accepts, rd_req_ready=0 and the third request stalls; busy=1.
  - Release ready -> responses 1, 2, 3 in order, data stable while stalled.
- Back-to-back reads of 8 addresses with rd_rsp_ready=1 -> 8 responses in 8 consecutive cycles, count never exceeds 1.
- With DEPTH=3000: read 0xBB8 -> data=0, err=1. Write to 0xBB8 followed by a read of 0x000 -> 0x000 unchanged.
- With mem[0x020]=5, read and write 0x020 (data 9) at the same edge -> response 5; the next read returns 9.
- Reset mid-operation, rst_n low for 1 cycle with 2 responses buffered -> rd_rsp_valid=0 immediately, no stale responses after release, prior writes still readable.
- Stats build: 5 reads plus 3 writes -> rd_count=5, wr_count=3.
